// File: rtl/regfile_read_unit.sv
// Read side of a 16 x 16-bit register file: one-hot wordline writes, two
// registered read ports with stall hold and R0 hardwired to zero.
// Optional macro REGFILE_READ_BYPASS_EN forwards same-edge write data to a matching read.
module regfile_read_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16,
  parameter int ID_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] WriteWordline,
  input  logic [DATA_W-1:0]   DstData,
  input  logic                ReadEn,
  input  logic                Stall,
  input  logic [ID_W-1:0]     SrcReg1,
  input  logic [ID_W-1:0]     SrcReg2,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  output logic                ReadValid,
  output logic                WordlineErr
);

  localparam logic [NUM_REGS-1:0] WL_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // R0 never participates in a read: its select bit is forced low, so the
  // AND-OR mux yields zero without any priority logic.
  function automatic logic [NUM_REGS-1:0] decode_id(input logic [ID_W-1:0] id);
    logic [NUM_REGS-1:0] sel;
    sel     = '0;
    sel[id] = 1'b1;
    sel[0]  = 1'b0;
    return sel;
  endfunction

  function automatic logic wl_is_multi(input logic [NUM_REGS-1:0] wl);
    return |(wl & (wl - WL_ONE));
  endfunction

  function automatic logic wl_is_single(input logic [NUM_REGS-1:0] wl);
    return (|wl) && !wl_is_multi(wl);
  endfunction

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic                wl_single;
  logic                wl_multi;
  logic [NUM_REGS-1:0] sel1;
  logic [NUM_REGS-1:0] sel2;
  logic [DATA_W-1:0]   rd1;
  logic [DATA_W-1:0]   rd2;
  logic [DATA_W-1:0]   nxt1;
  logic [DATA_W-1:0]   nxt2;

  logic [DATA_W-1:0]   src_data1_p1;
  logic [DATA_W-1:0]   src_data2_p1;
  logic                vld_p1;
  logic                wl_err;

  assign wl_single = wl_is_single(WriteWordline);
  assign wl_multi  = wl_is_multi(WriteWordline);

  // Array write: single-hot wordlines only; the R0 bit is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      wl_err <= 1'b0;
    end else begin
      if (wl_single) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (WriteWordline[i]) mem[i] <= DstData;
        end
      end
      if (wl_multi) wl_err <= 1'b1;
    end
  end

  // Read decode and AND-OR mux
  always_comb begin
    sel1 = decode_id(SrcReg1);
    sel2 = decode_id(SrcReg2);
    rd1  = '0;
    rd2  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd1 = rd1 | (mem[i] & {DATA_W{sel1[i]}});
      rd2 = rd2 | (mem[i] & {DATA_W{sel2[i]}});
    end
  end

`ifdef REGFILE_READ_BYPASS_EN
  // Write-before-read: sel has bit 0 cleared, so R0 can never hit.
  always_comb begin
    nxt1 = rd1;
    nxt2 = rd2;
    if (wl_single && |(sel1 & WriteWordline)) nxt1 = DstData;
    if (wl_single && |(sel2 & WriteWordline)) nxt2 = DstData;
  end
`else
  always_comb begin
    nxt1 = rd1;
    nxt2 = rd2;
  end
`endif

  // Stage p1: registered read result, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_data1_p1 <= '0;
      src_data2_p1 <= '0;
      vld_p1       <= 1'b0;
    end else if (!Stall) begin
      vld_p1 <= ReadEn;
      if (ReadEn) begin
        src_data1_p1 <= nxt1;
        src_data2_p1 <= nxt2;
      end
    end
  end

  assign SrcData1    = src_data1_p1;
  assign SrcData2    = src_data2_p1;
  assign ReadValid   = vld_p1;
  assign WordlineErr = wl_err;

endmodule

// File: tb/tb_regfile_read_unit.sv
// Scoreboard bench for regfile_read_unit: a behavioural model pushes the
// expected outputs for every clock edge; a negedge monitor pops and compares.
module tb_regfile_read_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ww;
  logic [15:0] dd;
  logic        ren;
  logic        stall;
  logic [3:0]  s1;
  logic [3:0]  s2;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        ReadValid;
  logic        WordlineErr;

  regfile_read_unit #(.DATA_W(16), .NUM_REGS(16), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .WriteWordline(ww), .DstData(dd),
    .ReadEn(ren), .Stall(stall), .SrcReg1(s1), .SrcReg2(s2),
    .SrcData1(SrcData1), .SrcData2(SrcData2),
    .ReadValid(ReadValid), .WordlineErr(WordlineErr)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [15:0] regs [16];
  exp_t        cur;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    cur.v = 1'b0; cur.d1 = 16'h0; cur.d2 = 16'h0; cur.err = 1'b0;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] id, input int pop);
    if (id == 4'd0) return 16'h0;
    if (BYPASS && pop == 1 && ww[id]) return dd;
    return regs[id];
  endfunction

  // Behaviour at one rising edge, from the rules of the register file.
  function automatic void model_edge();
    int pop;
    logic [15:0] v1, v2;
    if (!rst_n) begin
      model_clear();
    end else begin
      pop = $countones(ww);
      v1 = model_read(s1, pop);
      v2 = model_read(s2, pop);
      if (!stall) begin
        cur.v = ren;
        if (ren) begin cur.d1 = v1; cur.d2 = v2; end
      end
      if (pop == 1 && !ww[0]) begin
        for (int k = 1; k < 16; k++) if (ww[k]) regs[k] = dd;
      end
      if (pop > 1) cur.err = 1'b1;
    end
    q.push_back(cur);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [15:0] w, input logic [15:0] d, input logic re,
                       input logic st, input logic [3:0] a, input logic [3:0] b);
    ww = w; dd = d; ren = re; stall = st; s1 = a; s2 = b;
    step();
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    q.delete();
    model_clear();
    #1;
    chk("areset_d1", SrcData1, 16'h0);
    chk("areset_d2", SrcData2, 16'h0);
    chk("areset_vld", {15'h0, ReadValid}, 16'h0);
    chk("areset_err", {15'h0, WordlineErr}, 16'h0);
    step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ReadValid", {15'h0, ReadValid}, {15'h0, e.v});
      chk("SrcData1", SrcData1, e.d1);
      chk("SrcData2", SrcData2, e.d2);
      chk("WordlineErr", {15'h0, WordlineErr}, {15'h0, e.err});
    end
  end

  initial begin
    rst_n = 1'b0; ww = '0; dd = '0; ren = 1'b0; stall = 1'b0; s1 = '0; s2 = '0;
    model_clear();
    #3;
    chk("reset_d1", SrcData1, 16'h0);
    chk("reset_vld", {15'h0, ReadValid}, 16'h0);
    step();
    rst_n = 1'b1;

    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd3, 4'd15);   // reset then read
    drive(16'h0020, 16'hBEEF, 1'b0, 1'b0, 4'd0, 4'd0);    // R5 = BEEF
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd5, 4'd5);
    drive(16'h0080, 16'h1111, 1'b0, 1'b0, 4'd0, 4'd0);    // R7 = 1111
    drive(16'h0080, 16'h2222, 1'b1, 1'b0, 4'd7, 4'd7);    // bypass or not
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd7, 4'd0);
    drive(16'h0001, 16'hFFFF, 1'b0, 1'b0, 4'd0, 4'd0);    // R0 write discarded
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd0, 4'd0);
    drive(16'h0002, 16'h0101, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(16'h0004, 16'h0202, 1'b0, 1'b0, 4'd0, 4'd0);
    drive(16'h0006, 16'hAAAA, 1'b1, 1'b0, 4'd1, 4'd2);    // multi-hot
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd1, 4'd2);
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd5, 4'd15);   // stall hold
    drive(16'h0000, 16'h0000, 1'b1, 1'b1, 4'd0, 4'd0);
    drive(16'h0020, 16'h5555, 1'b1, 1'b1, 4'd0, 4'd0);
    drive(16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 4'd0);
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd5, 4'd5);
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 4'd5, 4'd7);
    async_reset();
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] id;
      id = 4'(i);
      drive(16'h0000, 16'h0000, 1'b1, 1'b0, id, 4'd15 - id);
    end

    for (int n = 0; n < 2000; n++) begin
      logic [15:0] w;
      int sel;
      int a, b;
      sel = $urandom_range(0, 99);
      if (sel < 55)       w = 16'h1 << $urandom_range(1, 15);
      else if (sel < 80)  w = 16'h0;
      else if (sel < 90)  w = 16'h0001;
      else if (sel < 93) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        w = (16'h1 << a) | (16'h1 << b);
      end else            w = 16'h1 << $urandom_range(1, 15);
      drive(w, 16'($urandom), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) == 0), 4'($urandom), 4'($urandom));
      if (n % 700 == 699) async_reset();
    end

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 16'(q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
